// File: rtl/ram_port.sv
// ram_port: single-port data memory responder for the CPU datapath's MAR/MDR
// interface. Requests arrive on a four-phase ramEnable handshake; after
// WAIT_CYCLES wait states the access is performed and ready is raised until
// ramEnable drops.
//
// Ports:
//   clock      rising-edge clock
//   clear      asynchronous active-low reset
//   ramEnable  level request strobe (four-phase)
//   memRead    1 = load, 0 = store (captured with the request)
//   MAR_addr   32-bit word address; bits above ADDR_W must be zero
//   MDR_wdata  store data
//   rdata      load data, valid while ready on a read
//   ready      access complete, held until ramEnable drops
//   busy       high whenever the FSM is not idle
//   err        address out of range, qualified by ready
//   perr       read parity mismatch, qualified by ready
//
// Optional feature: define RAM_PARITY_EN to store an even-parity bit per word
// and check it on reads. Without it perr is tied low.
module ram_port #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              ramEnable,
  input  logic              memRead,
  input  logic [31:0]       MAR_addr,
  input  logic [DATA_W-1:0] MDR_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic              perr
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;

  // Request captured in IDLE; inputs are ignored for the rest of the access.
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              rd_p0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              wr_en;

  assign in_range = (addr_p0[31:ADDR_W] == '0);
  assign idx      = addr_p0[ADDR_W-1:0];
  assign wr_en    = (state == ST_ACCESS) && !rd_p0 && in_range;

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic perr_q;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  // ---- capture stage: request registers (no reset, data only) ----
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && ramEnable) begin
      addr_p0  <= MAR_addr;
      wdata_p0 <= MDR_wdata;
      rd_p0    <= memRead;
    end
  end

  // ---- access stage: memory array write (contents survive reset) ----
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[idx]     <= wdata_p0;
`ifdef RAM_PARITY_EN
      par_mem[idx] <= even_par(wdata_p0);
`endif
    end
  end

  // ---- control FSM and registered outputs ----
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef RAM_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (ramEnable) begin
            busy     <= 1'b1;
            wait_cnt <= WAIT_INIT;
            state    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Leave on the edge where the counter reaches zero.
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          ready <= 1'b1;
          state <= ST_DONE;
          if (!in_range) begin
            err   <= 1'b1;
            rdata <= '0;
          end else if (rd_p0) begin
            rdata  <= mem[idx];
`ifdef RAM_PARITY_EN
            perr_q <= (par_mem[idx] != even_par(mem[idx]));
`endif
          end
        end
        ST_DONE: begin
          // A held ramEnable never retriggers; it must fall first.
          if (!ramEnable) begin
            ready  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
`ifdef RAM_PARITY_EN
            perr_q <= 1'b0;
`endif
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port.sv
module tb_ram_port;

  logic        clock = 1'b0;
  logic        clear [3];
  logic        en    [3];
  logic        rdn   [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        busy  [3];
  logic        err   [3];
  logic        perr  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Three instances: WAIT_CYCLES = 1 (default), 3, 0.
  for (genvar g = 0; g < 3; g++) begin : gen
    ram_port #(
      .ADDR_W     (9),
      .DATA_W     (32),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clock    (clock),
      .clear    (clear[g]),
      .ramEnable(en[g]),
      .memRead  (rdn[g]),
      .MAR_addr (addr[g]),
      .MDR_wdata(wd[g]),
      .rdata    (rdata[g]),
      .ready    (ready[g]),
      .busy     (busy[g]),
      .err      (err[g]),
      .perr     (perr[g])
    );
  end

  function automatic int wc(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  // Reference model: word array per instance plus the last load result.
  logic [31:0] mdl_mem  [3][512];
  logic [31:0] mdl_last [3];

  task automatic model(input int i, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] er,
                       output logic ee);
    if (a >= 32'd512) begin
      ee = 1'b1;
      mdl_last[i] = 32'h0;
    end else begin
      ee = 1'b0;
      if (rd) mdl_last[i] = mdl_mem[i][a];
      else    mdl_mem[i][a] = d;
    end
    er = mdl_last[i];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full handshake; called at #1 after a rising edge.
  task automatic access(input int i, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input string nm,
                        output logic [31:0] r, output logic e, output logic pe,
                        output int lat);
    en[i] = 1'b1; rdn[i] = rd; addr[i] = a; wd[i] = d;
    @(posedge clock); #1;
    chk({nm, "_busy_up"}, 32'(busy[i]), 32'd1);
    // Captured values must be used, not the live inputs.
    wd[i] = ~d; rdn[i] = ~rd;
    lat = 0;
    while (!ready[i] && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!ready[i]) begin
      errors++;
      $display("FAIL %s_timeout: ready=%0d expected 1", nm, ready[i]);
    end
    r = rdata[i]; e = err[i]; pe = perr[i];
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      chk({nm, "_hold_ready"}, 32'(ready[i]), 32'd1);
      chk({nm, "_hold_busy"},  32'(busy[i]),  32'd1);
    end
    en[i] = 1'b0;
    @(posedge clock); #1;
    chk({nm, "_drop_ready"}, 32'(ready[i]), 32'd0);
    chk({nm, "_drop_busy"},  32'(busy[i]),  32'd0);
    chk({nm, "_drop_err"},   32'(err[i]),   32'd0);
  endtask

  task automatic op(input int i, input logic rd, input logic [31:0] a,
                    input logic [31:0] d, input int hold,
                    input logic [31:0] exp_r, input logic exp_e,
                    input logic exp_pe, input string nm);
    logic [31:0] r; logic e, pe; int lat;
    access(i, rd, a, d, hold, nm, r, e, pe, lat);
    chk({nm, "_lat"},   32'(lat), 32'(wc(i) + 1));
    chk({nm, "_rdata"}, r, exp_r);
    chk({nm, "_err"},   32'(e),  32'(exp_e));
    chk({nm, "_perr"},  32'(pe), 32'(exp_pe));
  endtask

  task automatic mop(input int i, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input int hold, input string nm);
    logic [31:0] er; logic ee;
    model(i, rd, a, d, er, ee);
    op(i, rd, a, d, hold, er, ee, 1'b0, nm);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_r;
    logic        exp_e;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] er; logic ee;
    for (int i = 0; i < 3; i++) begin
      clear[i] = 1'b0; en[i] = 1'b0; rdn[i] = 1'b0;
      addr[i] = '0; wd[i] = '0; mdl_last[i] = '0;
    end

    tbl[0] = '{1'b0, 32'h0000_0087, 32'h0000_0043, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0087, 32'h0,         32'h0000_0043, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0000, 32'h0000_1111, 32'h0000_0043, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0200, 32'h0000_DEAD, 32'h0000_0000, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'h0,         32'h0000_1111, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0087, 32'h0,         32'h0000_0043, 1'b0};
    tbl[6] = '{1'b1, 32'h8000_0087, 32'h0,         32'h0000_0000, 1'b1};
    tbl[7] = '{1'b0, 32'h0000_01FF, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    tbl[8] = '{1'b1, 32'h0000_01FF, 32'h0,         32'hA5A5_A5A5, 1'b0};

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdata", rdata[i], 32'h0);
      chk("rst_ready", 32'(ready[i]), 32'd0);
      chk("rst_busy",  32'(busy[i]),  32'd0);
      chk("rst_err",   32'(err[i]),   32'd0);
      chk("rst_perr",  32'(perr[i]),  32'd0);
      clear[i] = 1'b1;
    end
    @(posedge clock); #1;

    // Directed vectors on the WAIT_CYCLES=1 instance.
    for (int v = 0; v < 9; v++) begin
      model(0, tbl[v].rd, tbl[v].a, tbl[v].d, er, ee);
      op(0, tbl[v].rd, tbl[v].a, tbl[v].d, 0, tbl[v].exp_r, tbl[v].exp_e, 1'b0,
         $sformatf("vec%0d", v));
    end

    // Held handshake: ready/busy stay high, then a fresh access starts.
    mop(0, 1'b0, 32'h30, 32'hCAFE_F00D, 10, "held_wr");
    mop(0, 1'b1, 32'h30, 32'h0, 0, "held_rd");

    // Zero wait states.
    mop(2, 1'b0, 32'h44, 32'h0BAD_BEEF, 0, "w0_wr");
    mop(2, 1'b1, 32'h44, 32'h0, 0, "w0_rd");

    // Reset in the second wait cycle drops a pending store.
    mop(1, 1'b0, 32'h10, 32'h1234_5678, 0, "pre_wr");
    mop(1, 1'b1, 32'h10, 32'h0, 0, "pre_rd");
    en[1] = 1'b1; rdn[1] = 1'b0; addr[1] = 32'h10; wd[1] = 32'h55;
    @(posedge clock); #1;
    @(posedge clock); #2;
    clear[1] = 1'b0;
    #1;
    chk("abort_rdata", rdata[1], 32'h0);
    chk("abort_ready", 32'(ready[1]), 32'd0);
    chk("abort_busy",  32'(busy[1]),  32'd0);
    chk("abort_err",   32'(err[1]),   32'd0);
    chk("abort_perr",  32'(perr[1]),  32'd0);
    en[1] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    clear[1] = 1'b1;
    mdl_last[1] = 32'h0;
    @(posedge clock); #1;
    mop(1, 1'b1, 32'h10, 32'h0, 0, "post_rst_rd");

`ifdef RAM_PARITY_EN
    mop(0, 1'b0, 32'h20, 32'h1, 0, "par_wr");
    gen[0].u_dut.par_mem[9'h20] = ~gen[0].u_dut.par_mem[9'h20];
    model(0, 1'b1, 32'h20, 32'h0, er, ee);
    op(0, 1'b1, 32'h20, 32'h0, 0, 32'h1, 1'b0, 1'b1, "par_rd");
`endif

    // Randomized traffic against the model on every instance.
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < 16; a++)
        mop(i, 1'b0, 32'(a), $urandom, 0, "fill");
      for (int n = 0; n < 40; n++) begin
        logic        rd;
        logic [31:0] a;
        rd = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h200)
                                         : 32'($urandom_range(0, 15));
        mop(i, rd, a, $urandom, $urandom_range(0, 2), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port.md
# ram_port

Single-port 512×32 data memory responder that services the CPU datapath's MAR/MDR memory interface. It accepts read (load) and write (store) requests on a four-phase `ramEnable` handshake. It applies a programmable number of wait states and returns read data with a `ready` acknowledge. The datapath's store/load microsteps drive it as the memory-side endpoint.

## Interface
- `ADDR_W`, 9, word-address width; depth = 2^ADDR_W.
- `DATA_W`, 32, word width.
- `WAIT_CYCLES`, 1, wait states inserted before the access (0–15).

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `ramEnable`  in  1  request strobe, level-sensitive, four-phase.
- `memRead`  in  1  1 = read (load), 0 = write (store); sampled with the request.
- `MAR_addr`  in  32  word address from MAR.
- `MDR_wdata`  in  DATA_W  store data from MDR.
- `rdata`  out  DATA_W  load data to MDR; valid while `ready`=1 on a read.
- `ready`  out  1  access complete; held until `ramEnable` drops.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  address out of range; qualified by `ready`.
- `perr`  out  1  read parity mismatch; qualified by `ready` (see Configuration).

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE, `ramEnable`=1:
  - Capture `MAR_addr`, `MDR_wdata` and `memRead` into internal registers.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT, or go directly to ACCESS if WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle. Go to ACCESS on the edge the counter reaches 0. Input changes are ignored; the captured values are used.
- ACCESS:
  - Range check: if captured `MAR_addr[31:ADDR_W]` ≠ 0, set `err`=1, write nothing, and set `rdata`=0.
  - Write: `mem[addr]` ← captured data. `rdata` keeps its previous value.
  - Read: `rdata` ← `mem[addr]`.
  - Set `ready`=1 and go to DONE.
- DONE: hold `ready`, `rdata`, `err` and `perr`. When `ramEnable`=0, clear `ready`, `err` and `perr`, and go to IDLE.
- If `ramEnable` is still high in DONE, no new request is started. Each new request needs a low-then-high transition on `ramEnable`.
- `ramEnable` dropping during WAIT or ACCESS does not abort the access. The FSM still passes through DONE; `ready` is high for one cycle and then clears.
- Memory contents are undefined at power-up and are not cleared by reset.

## Timing
- Reset values: state=IDLE, `rdata`=0, `ready`=0, `busy`=0, `err`=0, `perr`=0, wait counter=0.
- Request sampled at edge k. ACCESS is executed at edge k+WAIT_CYCLES+1. `ready`, `rdata` and `err` are registered and visible after that edge.
  - Latency is WAIT_CYCLES+1 cycles; with the default, `ready` is seen 2 cycles after the request.
- `busy` goes high after edge k. It falls on the edge where DONE returns to IDLE.
- A write commits at the ACCESS edge. A read issued right after a write to the same address returns the new data.
- Reset is asserted asynchronously and takes effect immediately. An access in progress is dropped: if reset lands before the ACCESS edge, no write occurs.
- Deassertion of `clear` is synchronised by the system. The first request can be captured on the first rising edge after `clear` goes high.

## Configuration
- `RAM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed from the write data at ACCESS.
  - A read recomputes parity over the stored word. `perr`=1 with `ready` on a mismatch; `rdata` still returns the stored word.
- Not defined: there is no parity storage and `perr` is tied to 0.

## Test plan
- Write, then read back, WAIT_CYCLES=1:
  - Write `MAR_addr`=0x87 with `MDR_wdata`=0x43 → `ready` 2 cycles after the request, `err`=0.
  - Drop `ramEnable` → `ready`=0 the next cycle.
  - Read 0x87 → `rdata`=0x00000043.
- Out of range: write `MAR_addr`=0x200 with data 0xDEAD → `err`=1 and `ready`=1. A following read of 0x000 returns its old value, unchanged.
- Held handshake: keep `ramEnable` high for 10 cycles after `ready` → `ready` stays 1, `busy` stays 1, and there is exactly one write. Lowering and then raising `ramEnable` starts a second access.
- Reset during WAIT (WAIT_CYCLES=3): write 0x55 to 0x10, then pull `clear` low in the 2nd wait cycle → all outputs go to 0 at once. A later read of 0x10 returns the pre-test value.
- WAIT_CYCLES=0: read request at edge k → `ready` with valid `rdata` after edge k+1.
- `RAM_PARITY_EN` defined: write 0x1 to 0x20, then force that word's stored parity bit inverted, then read 0x20 → `rdata`=0x1 and `perr`=1. Without the macro, `perr`=0 throughout.
